// File: rtl/sprite_reg_writer.sv
// Sprite/score register writer: buffers register updates in a FIFO
// and replays them as Avalon-MM writes only inside vertical blank.
module sprite_reg_writer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int MAX_WR = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic                     VGA_VS,
  output logic                     chipselect,
  output logic                     write,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        writedata,
  input  logic                     waitrequest,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              frame_count,
  output logic                     burst_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(MAX_WR + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [BW-1:0] MAX_C   = BW'(MAX_WR);

  typedef enum logic {
    S_WAIT_VB,
    S_ISSUE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [BW-1:0]     r_budget;
  logic              r_vs_q;
  logic [15:0]       r_frames;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_done;

  logic              w_push;
  logic              w_pop;
  logic              w_vb_start;
  logic              w_more;
  logic [PW-1:0]     w_rptr_nx;
  logic [ADDR_W-1:0] w_next_addr;
  logic [DATA_W-1:0] w_next_data;

  assign cmd_ready   = (r_count < DEPTH_C);
  assign w_push      = cmd_valid & cmd_ready;
  assign w_pop       = (r_state == S_ISSUE) & r_write & ~waitrequest;
  assign w_vb_start  = r_vs_q & ~VGA_VS;
  assign w_rptr_nx   = r_rptr + PW'(1);

  // Next head after a pop; a lone entry being popped hands over
  // to a same-cycle push straight from the command inputs.
  assign w_next_addr = (r_count > CW'(1)) ? r_mem_addr[w_rptr_nx] : cmd_addr;
  assign w_next_data = (r_count > CW'(1)) ? r_mem_data[w_rptr_nx] : cmd_data;
  assign w_more      = (r_budget > BW'(1)) & ((r_count > CW'(1)) | w_push);

  assign chipselect  = r_write;
  assign write       = r_write;
  assign address     = r_addr;
  assign writedata   = r_data;
  assign fifo_count  = r_count;
  assign frame_count = r_frames;
  assign burst_done  = r_done;

  // FIFO storage; contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= cmd_addr;
      r_mem_data[r_wptr] <= cmd_data;
    end
  end

  // FIFO pointers and occupancy, head counted until its beat is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= w_rptr_nx;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sync edge detector and frame counter, independent of FSM state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_q   <= 1'b1;
      r_frames <= '0;
    end else begin
      r_vs_q <= VGA_VS;
      if (w_vb_start) r_frames <= r_frames + 16'd1;
    end
  end

  // Burst FSM with registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_WAIT_VB;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_budget <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_WAIT_VB: begin
          r_write <= 1'b0;
          if (w_vb_start) begin
            if (r_count != '0) begin
              r_budget <= MAX_C;
              r_addr   <= r_mem_addr[r_rptr];
              r_data   <= r_mem_data[r_rptr];
              r_write  <= 1'b1;
              r_state  <= S_ISSUE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_pop) begin
            r_budget <= r_budget - BW'(1);
            if (w_more) begin
              r_addr <= w_next_addr;
              r_data <= w_next_data;
            end else begin
              r_write <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_WAIT_VB;
            end
          end
        end
        default: r_state <= S_WAIT_VB;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_reg_writer.sv
// Scoreboard bench for sprite_reg_writer: directed pushes and blanks,
// a negedge monitor pops expected writes on every accepted beat.
module tb_sprite_reg_writer;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int MAXW  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          VGA_VS;
  logic          chipselect;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
  logic          waitrequest;
  logic [4:0]    fifo_count;
  logic [15:0]   frame_count;
  logic          burst_done;

  sprite_reg_writer #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MAX_WR(MAXW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .VGA_VS(VGA_VS),
    .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata),
    .waitrequest(waitrequest),
    .fifo_count(fifo_count), .frame_count(frame_count),
    .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [AW+DW-1:0] exp_q [$];
  logic [15:0] exp_frames = 16'd0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted beat must match the oldest expected write
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (reset_n && write && !waitrequest) begin
      beats++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 address, writedata);
      end else begin
        e = exp_q.pop_front();
        if ({chipselect, address, writedata} !== {1'b1, e}) begin
          errors++;
          $display("FAIL beat: got cs %0b addr %0h data %0h expected addr %0h data %0h",
                   chipselect, address, writedata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("push_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back({a, d});
  endtask

  task automatic wait_burst;
    bit got = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (burst_done) begin
        got = 1;
        break;
      end
    end
    chk("burst_done_seen", got, 1);
  endtask

  task automatic blank_burst;
    VGA_VS = 1'b0;
    exp_frames++;
    wait_burst();
    tick();
    VGA_VS = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int exp_n [3] = '{4, 4, 2};
    int exp_c [3] = '{6, 2, 0};

    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_data    = '0;
    VGA_VS      = 1'b1;
    waitrequest = 1'b0;
    #1;
    chk("rst_bus", {chipselect, write, address, writedata}, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_ready", cmd_ready, 1);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Basic two-write burst, first beat one cycle after the sync edge
    push(9'd0, 32'd100);
    push(9'd1, 32'd80);
    chk("basic_count", fifo_count, 2);
    b0 = beats;
    VGA_VS = 1'b0;
    exp_frames++;
    tick();
    chk("basic_first", {write, address, writedata}, {1'b1, 9'd0, 32'd100});
    tick();
    chk("basic_second", {write, address, writedata}, {1'b1, 9'd1, 32'd80});
    wait_burst();
    tick();
    VGA_VS = 1'b1;
    tick();
    chk("basic_beats", beats - b0, 2);
    chk("basic_empty", fifo_count, 0);
    chk("basic_frames", frame_count, exp_frames);

    // Budget: ten commands drain 4,4,2 across three blanks
    for (int i = 0; i < 10; i++) push(9'(16 + i), 32'(1000 + i));
    chk("budget_count", fifo_count, 10);
    for (int k = 0; k < 3; k++) begin
      b0 = beats;
      blank_burst();
      chk("budget_beats", beats - b0, exp_n[k]);
      chk("budget_left", fifo_count, exp_c[k]);
    end

    // Stall on the second beat for three cycles
    push(9'd40, 32'hA);
    push(9'd41, 32'hB);
    push(9'd42, 32'hC);
    VGA_VS = 1'b0;
    exp_frames++;
    tick();
    tick();
    waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_hold", {write, address, writedata}, {1'b1, 9'd41, 32'hB});
      chk("stall_count", fifo_count, 2);
      tick();
    end
    waitrequest = 1'b0;
    chk("stall_last", {write, address, writedata}, {1'b1, 9'd41, 32'hB});
    tick();
    chk("stall_next", {write, address, writedata}, {1'b1, 9'd42, 32'hC});
    wait_burst();
    tick();
    VGA_VS = 1'b1;
    tick();
    chk("stall_empty", fifo_count, 0);

    // Full FIFO: push during the first pop is refused
    for (int i = 0; i < DEPTH; i++) push(9'(100 + i), 32'(32'h5000 + i));
    chk("full_ready", cmd_ready, 0);
    chk("full_count", fifo_count, 16);
    VGA_VS = 1'b0;
    exp_frames++;
    tick();
    chk("full_write", write, 1);
    cmd_valid = 1'b1;
    cmd_addr  = 9'h1FF;
    cmd_data  = 32'hDEAD;
    tick();
    cmd_valid = 1'b0;
    chk("full_reject_count", fifo_count, 15);
    chk("full_ready_after", cmd_ready, 1);
    wait_burst();
    tick();
    VGA_VS = 1'b1;
    tick();
    chk("full_after_blank", fifo_count, 12);
    repeat (3) blank_burst();
    chk("full_drained", fifo_count, 0);

    // Push into the slot freed by the last pop continues the burst
    push(9'd200, 32'h77);
    VGA_VS = 1'b0;
    exp_frames++;
    tick();
    cmd_valid = 1'b1;
    cmd_addr  = 9'd201;
    cmd_data  = 32'h78;
    exp_q.push_back({9'd201, 32'h78});
    tick();
    cmd_valid = 1'b0;
    chk("bypass_count", fifo_count, 1);
    chk("bypass_beat", {write, address, writedata}, {1'b1, 9'd201, 32'h78});
    wait_burst();
    tick();
    VGA_VS = 1'b1;
    tick();
    chk("bypass_empty", fifo_count, 0);

    // Empty blanks: no writes, burst_done every time
    b0 = beats;
    for (int i = 0; i < 1000; i++) begin
      VGA_VS = 1'b0;
      exp_frames++;
      tick();
      chk("empty_done", {burst_done, write}, 2'b10);
      VGA_VS = 1'b1;
      tick();
    end
    chk("empty_beats", beats - b0, 0);
    chk("empty_frames", frame_count, exp_frames);

    // Reset mid-burst drops the beat and the FIFO
    push(9'd300, 32'h300);
    push(9'd301, 32'h301);
    push(9'd302, 32'h302);
    VGA_VS = 1'b0;
    tick();
    chk("rst_mid_write", write, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_bus", {chipselect, write}, 0);
    chk("rst_mid_count", fifo_count, 0);
    chk("rst_mid_frames", frame_count, 0);
    exp_q.delete();
    exp_frames = 16'd0;
    VGA_VS = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    b0 = beats;
    VGA_VS = 1'b0;
    exp_frames++;
    tick();
    chk("rst_lost_done", {burst_done, write}, 2'b10);
    VGA_VS = 1'b1;
    tick();
    tick();
    chk("rst_lost_beats", beats - b0, 0);
    chk("rst_frames_after", frame_count, exp_frames);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
